async_fifo_wr_ctrl: RTL and testbench

Write-side pointer and flag controller for the dual-clock asynchronous FIFO. It runs entirely in the write clock domain. It takes write requests, drives the FIFO memory write port, and keeps the binary and Gray write pointers. It synchronises the read domain's Gray pointer through a two-stage flop chain and generates registered full, almost-full, fill level and a sticky overflow flag.

---
 rtl/fifo_pkg.sv | 35 +++
 rtl/ptr_sync2.sv | 32 +++
 rtl/async_fifo_wr_ctrl.sv | 96 +++++++++
 tb/tb_async_fifo_wr_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer helpers for the dual-clock FIFO
//
// Purpose : pointer-width derivation and binary/Gray conversion shared by
//           both FIFO domains.
// Contents: PTR_MAX  - widest pointer the helpers handle
//           ptr_w    - pointer width for a given address width (one wrap bit)
//           bin2gray - binary to reflected Gray code
//           gray2bin - reflected Gray code back to binary
// The helpers work on PTR_MAX-wide values. Callers zero-extend a PW-bit
// pointer in and size-cast the result back to PW bits. Zero upper bits pass
// through both conversions unchanged, so one pair of functions serves every
// pointer width.

package fifo_pkg;

  localparam int PTR_MAX = 32;

  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b = g;
    for (int i = 1; i < PTR_MAX; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync2.sv
// rtl/ptr_sync2.sv - two-flop synchroniser for a Gray-coded pointer
//
// Purpose : brings a Gray pointer from the other clock domain into clk.
//           Only one bit changes per source update, so each stage can sample
//           it as a bus.
// Ports   : clk   - destination clock
//           rst_n - asynchronous active-low reset, clears both stages
//           d     - pointer from the foreign domain
//           q     - synchronised pointer (second stage)

module ptr_sync2 #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] rq1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq1 <= '0;
      q   <= '0;
    end else begin
      rq1 <= d;
      q   <= rq1;
    end
  end

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// rtl/async_fifo_wr_ctrl.sv - write-side pointer and flag controller
//
// Purpose : write-clock-domain half of the dual-clock FIFO. It accepts write
//           requests and drives the memory write port. It keeps the binary
//           and Gray write pointers and derives full, almost-full, fill level
//           and a sticky overflow from the synchronised read pointer.
// Ports   : clk         - write-domain clock
//           rst_n       - asynchronous active-low reset
//           wr_en       - write request, accepted while full is low
//           ovf_clr     - synchronous clear of overflow (a same-cycle set wins)
//           rd_ptr_gray - read-domain Gray pointer, asynchronous to clk
//           mem_we      - memory write strobe (combinational)
//           mem_waddr   - memory write address
//           wr_ptr_gray - registered Gray write pointer for the read domain
//           full        - registered full flag
//           almost_full - registered, level >= AFULL_LVL
//           wr_level    - registered fill level, 0..2^ADDR_W
//           overflow    - sticky, set by a write attempted while full
// The read pointer reaches this domain late, so full, level and almost_full
// can over-report occupancy but never under-report it.

module async_fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter  int ADDR_W    = 2,
  parameter  int AFULL_LVL = 3,
  localparam int PW        = ptr_w(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              ovf_clr,
  input  logic [PW-1:0]     rd_ptr_gray,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [PW-1:0]     wr_ptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [PW-1:0]     wr_level,
  output logic              overflow
);

  // The write pointer is full when it is exactly one lap ahead of the read
  // pointer. In Gray code that means the top two bits are inverted.
  localparam logic [PW-1:0] TOP2    = PW'(3) << (PW - 2);
  localparam logic [PW-1:0] AFULL_P = PW'(AFULL_LVL);

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rbin;
  logic [PW-1:0] wbin_nxt;
  logic [PW-1:0] wgray_nxt;
  logic [PW-1:0] lvl_nxt;
  logic          inc;

  ptr_sync2 #(.W(PW)) u_rd_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rd_ptr_gray),
    .q     (rq2)
  );

  assign rbin      = PW'(gray2bin(PTR_MAX'(rq2)));
  assign inc       = wr_en & ~full;
  assign wbin_nxt  = wr_bin + {{(PW-1){1'b0}}, inc};
  assign wgray_nxt = PW'(bin2gray(PTR_MAX'(wbin_nxt)));
  // Modular difference. The extra wrap bit keeps a full FIFO distinct from
  // an empty one.
  assign lvl_nxt   = wbin_nxt - rbin;

  assign mem_we    = inc;
  assign mem_waddr = wr_bin[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_bin      <= wbin_nxt;
      wr_ptr_gray <= wgray_nxt;
      full        <= (wgray_nxt == (rq2 ^ TOP2));
      wr_level    <= lvl_nxt;
      almost_full <= (lvl_nxt >= AFULL_P);
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb/tb_async_fifo_wr_ctrl.sv - scoreboard bench for async_fifo_wr_ctrl

module tb_async_fifo_wr_ctrl;

  typedef struct {
    logic [2:0] gray;
    logic       full;
    logic       afull;
    logic [2:0] level;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [2:0] rd_ptr_gray = 3'd0;
  logic       mem_we;
  logic [1:0] mem_waddr;
  logic [2:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [2:0] wr_level;
  logic       overflow;

  // Reference Gray sequence for a 3-bit pointer.
  logic [2:0] gtab [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb [$];

  // Count-based model: m_w counts accepted writes. rcount counts reads done
  // by the read side. m_r1/m_r2 are the read counts seen through the
  // two-stage synchroniser.
  int   m_w = 0;
  int   m_r1 = 0;
  int   m_r2 = 0;
  int   rcount = 0;
  logic m_full = 1'b0;
  logic m_ovf = 1'b0;

  async_fifo_wr_ctrl #(.ADDR_W(2), .AFULL_LVL(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .ovf_clr     (ovf_clr),
    .rd_ptr_gray (rd_ptr_gray),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .wr_ptr_gray (wr_ptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " wr_ptr_gray"}, 32'(wr_ptr_gray), 32'd0);
    check({tag, " full"},        32'(full),        32'd0);
    check({tag, " almost_full"}, 32'(almost_full), 32'd0);
    check({tag, " wr_level"},    32'(wr_level),    32'd0);
    check({tag, " overflow"},    32'(overflow),    32'd0);
    check({tag, " mem_waddr"},   32'(mem_waddr),   32'd0);
    check({tag, " mem_we"},      32'(mem_we),      32'(wr_en));
  endtask

  task automatic model_reset();
    m_w = 0; m_r1 = 0; m_r2 = 0; rcount = 0;
    m_full = 1'b0; m_ovf = 1'b0;
    rd_ptr_gray = 3'd0;
  endtask

  // One write-clock cycle: drive at the falling edge, check the combinational
  // port, push the post-edge expectation, then pop and compare after the edge.
  task automatic step(input logic we, input logic clr);
    exp_t e;
    int   w_new;
    logic acc;
    @(negedge clk);
    wr_en = we;
    ovf_clr = clr;
    rd_ptr_gray = gtab[rcount % 8];
    #1;
    check("mem_we", 32'(mem_we), 32'(we & ~m_full));
    check("mem_waddr", 32'(mem_waddr), 32'(m_w % 4));
    acc     = we & ~m_full;
    w_new   = m_w + int'(acc);
    e.gray  = gtab[w_new % 8];
    e.level = 3'(w_new - m_r2);
    e.full  = ((w_new - m_r2) == 4);
    e.afull = ((w_new - m_r2) >= 3);
    e.ovf   = (we & m_full) | (m_ovf & ~clr);
    sb.push_back(e);
    m_w = w_new; m_full = e.full; m_ovf = e.ovf;
    m_r2 = m_r1; m_r1 = rcount;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("wr_ptr_gray", 32'(wr_ptr_gray), 32'(e.gray));
    check("full",        32'(full),        32'(e.full));
    check("almost_full", 32'(almost_full), 32'(e.afull));
    check("wr_level",    32'(wr_level),    32'(e.level));
    check("overflow",    32'(overflow),    32'(e.ovf));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    model_reset();
    // Reset held: outputs 0 and the write strobe follows wr_en.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_en = 1'($urandom_range(0, 1));
      #1 check_all_zero("reset");
    end
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;

    // Fill: four writes with the read pointer at 0.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    check("fill full", 32'(full), 32'd1);
    check("fill level", 32'(wr_level), 32'd4);
    check("fill gray", 32'(wr_ptr_gray), 32'h6);

    // Overflow: writes while full, then a clear, then a clear racing a set.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    check("ovf gray held", 32'(wr_ptr_gray), 32'h6);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("ovf set wins", 32'(overflow), 32'd1);
    step(1'b0, 1'b1);

    // Read latency: one read, visible in the flags two edges later.
    rcount = 1;
    step(1'b0, 1'b0);
    check("lat full E", 32'(full), 32'd1);
    step(1'b0, 1'b0);
    check("lat full E+1", 32'(full), 32'd1);
    step(1'b0, 1'b0);
    check("lat full E+2", 32'(full), 32'd0);
    check("lat level E+2", 32'(wr_level), 32'd3);

    // Refill, then a read advance and a write applied on the same edge.
    step(1'b1, 1'b0);
    rcount = 2;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    rcount = 3;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Wrap-around: writes with the reader trailing.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
      if (m_w - rcount > 1) rcount++;
    end

    // Random traffic. The reader never passes the writer.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1 && rcount < m_w) rcount++;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    // Bring the level to 2, then reset between edges.
    rcount = m_w - 2;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    check("pre-reset level", 32'(wr_level), 32'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
